// File: rtl/wb_ips_xbar_ctrl_if.sv
// Bus bundle for wb_ips_xbar_ctrl: master-side Wishbone port, the N_SLAVES
// IP-side ports and the sticky error reporting signals.
interface wb_ips_xbar_ctrl_if #(
  parameter int unsigned N_SLAVES = 4
);
  // Master-side Wishbone
  logic                     wbs_cyc_i;
  logic                     wbs_stb_i;
  logic                     wbs_we_i;
  logic [3:0]               wbs_sel_i;
  logic [31:0]              wbs_adr_i;
  logic [31:0]              wbs_dat_i;
  logic                     wbs_ack_o;
  logic [31:0]              wbs_dat_o;
  // IP-side ports
  logic [N_SLAVES-1:0]      s_cyc_o;
  logic [N_SLAVES-1:0]      s_stb_o;
  logic                     s_we_o;
  logic [3:0]               s_sel_o;
  logic [31:0]              s_adr_o;
  logic [31:0]              s_dat_o;
  logic [32*N_SLAVES-1:0]   s_dat_i;
  logic [N_SLAVES-1:0]      s_ack_i;
  // Error reporting
  logic                     err_clr_i;
  logic                     err_o;
  logic [31:0]              err_adr_o;

  // Controller view
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    input  err_clr_i,
    output err_o, err_adr_o
  );

  // Environment view (SoC master plus the IP slaves)
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i,
    output err_clr_i,
    input  err_o, err_adr_o
  );
endinterface

// File: rtl/wb_ips_xbar_ctrl.sv
// Shares one Wishbone slave port between N_SLAVES IPs, one transaction at a
// time, with address decode, registered single-cycle ack and a sticky error.
// Optional hung-slave timeout is built when XBAR_TIMEOUT_EN is defined.
module wb_ips_xbar_ctrl #(
  parameter int unsigned N_SLAVES       = 4,
  parameter logic [7:0]  BASE_HI        = 8'h30,
  parameter int unsigned SEL_LSB        = 16,
`ifdef XBAR_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  wb_ips_xbar_ctrl_if.slave   bus
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR,
    ST_RESP
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_wbs_ack;
  logic [31:0]         r_wbs_dat;
  logic [N_SLAVES-1:0] r_s_cyc;
  logic [N_SLAVES-1:0] r_s_stb;
  logic                r_s_we;
  logic [3:0]          r_s_sel;
  logic [31:0]         r_s_adr;
  logic [31:0]         r_s_dat;
  logic                r_err;
  logic [31:0]         r_err_adr;

  logic [IDX_W-1:0]    w_idx;
  logic                w_req;
  logic                w_req_valid;
  logic [N_SLAVES-1:0] w_req_mask;
  logic [N_SLAVES-1:0] w_sel_mask;
  logic                w_sel_ack;
  logic [31:0]         w_sel_dat;
  logic                w_timeout;

  // Address decode of the incoming request
  assign w_idx       = bus.wbs_adr_i[SEL_LSB+IDX_W-1:SEL_LSB];
  assign w_req       = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign w_req_valid = (bus.wbs_adr_i[31:24] == BASE_HI) && (32'(w_idx) < N_SLAVES);
  assign w_req_mask  = N_SLAVES'(1) << w_idx;

  // Only the ack of the slave that owns the transaction is observed
  assign w_sel_mask  = N_SLAVES'(1) << r_idx;
  assign w_sel_ack   = |(bus.s_ack_i & w_sel_mask);

  // Read-data mux for the selected slave
  always_comb begin
    w_sel_dat = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_dat = bus.s_dat_i[32*i +: 32];
      end
    end
  end

`ifdef XBAR_TIMEOUT_EN
  logic [15:0] r_cnt;

  // BUSY-cycle counter; held at zero outside BUSY so it restarts on every entry
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = ((r_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // Transaction FSM with all bus-facing outputs registered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_wbs_ack <= 1'b0;
      r_wbs_dat <= '0;
      r_s_cyc   <= '0;
      r_s_stb   <= '0;
      r_s_we    <= 1'b0;
      r_s_sel   <= '0;
      r_s_adr   <= '0;
      r_s_dat   <= '0;
      r_err     <= 1'b0;
      r_err_adr <= '0;
    end else begin
      // A set issued later in this block overrides the clear
      if (bus.err_clr_i) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_wbs_ack <= 1'b0;
          if (w_req) begin
            r_s_we  <= bus.wbs_we_i;
            r_s_sel <= bus.wbs_sel_i;
            r_s_adr <= bus.wbs_adr_i;
            r_s_dat <= bus.wbs_dat_i;
            r_idx   <= w_idx;
            if (w_req_valid) begin
              r_s_cyc <= w_req_mask;
              r_s_stb <= w_req_mask;
              r_state <= ST_BUSY;
            end else begin
              r_wbs_dat <= ERR_DATA;
              r_err     <= 1'b1;
              r_err_adr <= bus.wbs_adr_i;
              r_state   <= ST_ERR;
            end
          end
        end

        ST_BUSY: begin
          if (w_sel_ack) begin
            r_wbs_dat <= w_sel_dat;
            r_s_cyc   <= '0;
            r_s_stb   <= '0;
            r_wbs_ack <= 1'b1;
            r_state   <= ST_RESP;
          end else if (!bus.wbs_cyc_i) begin
            r_s_cyc <= '0;
            r_s_stb <= '0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_s_cyc   <= '0;
            r_s_stb   <= '0;
            r_wbs_dat <= ERR_DATA;
            r_err     <= 1'b1;
            r_err_adr <= r_s_adr;
            r_state   <= ST_ERR;
          end
        end

        ST_ERR: begin
          r_wbs_ack <= 1'b1;
          r_state   <= ST_RESP;
        end

        ST_RESP: begin
          r_wbs_ack <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_wbs_ack <= 1'b0;
          r_s_cyc   <= '0;
          r_s_stb   <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wbs_ack_o = r_wbs_ack;
  assign bus.wbs_dat_o = r_wbs_dat;
  assign bus.s_cyc_o   = r_s_cyc;
  assign bus.s_stb_o   = r_s_stb;
  assign bus.s_we_o    = r_s_we;
  assign bus.s_sel_o   = r_s_sel;
  assign bus.s_adr_o   = r_s_adr;
  assign bus.s_dat_o   = r_s_dat;
  assign bus.err_o     = r_err;
  assign bus.err_adr_o = r_err_adr;

endmodule

// File: tb/tb_wb_ips_xbar_ctrl.sv
// Self-checking bench for wb_ips_xbar_ctrl: behavioural slaves with
// programmable ack delay, expected responses queued at request time.
module tb_wb_ips_xbar_ctrl;

  localparam int unsigned N_SLAVES = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          NEVER    = 100000;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_ips_xbar_ctrl_if #(.N_SLAVES(N_SLAVES)) bus ();

  wb_ips_xbar_ctrl #(
    .N_SLAVES       (N_SLAVES),
    .BASE_HI        (8'h30),
    .SEL_LSB        (16),
`ifdef XBAR_TIMEOUT_EN
    .TIMEOUT_CYCLES (8),
`endif
    .ERR_DATA       (ERR_DATA)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb_q[$];
  int          ack_delay[N_SLAVES];
  logic [31:0] rdata[N_SLAVES];
  int          scnt[N_SLAVES];

  // Slave models: ack 'ack_delay' cycles after the strobe first appears
  always @(negedge clk) begin
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      bus.s_dat_i[32*i +: 32] = rdata[i];
      if (bus.s_stb_o[i] === 1'b1 && bus.s_cyc_o[i] === 1'b1) begin
        bus.s_ack_i[i] = (scnt[i] == ack_delay[i]);
        scnt[i]++;
      end else begin
        bus.s_ack_i[i] = 1'b0;
        scnt[i] = 0;
      end
    end
  end

  task automatic drive_req(input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
  endtask

  task automatic drop_req;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] dat, input logic err);
    exp_t e;
    e.dat = dat;
    e.err = err;
    sb_q.push_back(e);
  endtask

  // Advance until an ack is seen or the budget runs out; gathers observations only
  task automatic wait_ack(input int budget, output int lat, output int stb_cyc,
                          output logic [N_SLAVES-1:0] stb_or, output bit got,
                          output logic [31:0] dat, output logic err);
    lat = 0; stb_cyc = 0; stb_or = '0; got = 1'b0; dat = '0; err = 1'b0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      bus.err_clr_i = 1'b0;
      if (bus.s_stb_o !== '0) begin
        stb_cyc++;
        stb_or |= bus.s_stb_o;
      end
      if (bus.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        dat = bus.wbs_dat_o;
        err = bus.err_o;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drop_req();
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.wbs_ack_o, bus.s_cyc_o, bus.s_stb_o, bus.err_o} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: ack/cyc/stb/err=%b expected all zero",
               {bus.wbs_ack_o, bus.s_cyc_o, bus.s_stb_o, bus.err_o});
    end
    n_vec++;
    if ({bus.wbs_dat_o, bus.s_adr_o, bus.s_dat_o, bus.err_adr_o, bus.s_sel_o, bus.s_we_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: dat_o=%h adr=%h sdat=%h err_adr=%h expected zero",
               bus.wbs_dat_o, bus.s_adr_o, bus.s_dat_o, bus.err_adr_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read;
    int lat, sc; logic [N_SLAVES-1:0] so; bit got; logic [31:0] d; logic e; exp_t x;
    ack_delay[1] = 0; rdata[1] = 32'h1234_5678;
    drive_req(32'h3001_0004, 1'b0, 32'h0, 4'hF);
    push_exp(32'h1234_5678, 1'b0);
    wait_ack(20, lat, sc, so, got, d, e);
    drop_req();
    n_vec++;
    if (!got || lat != 2) begin n_err++; $display("FAIL read_latency: got=%0d lat=%0d expected 2", got, lat); end
    n_vec++;
    if (so !== 4'b0010 || sc != 1) begin n_err++; $display("FAIL read_strobe: mask=%b cycles=%0d expected 0010 x1", so, sc); end
    n_vec++;
    x = sb_q.pop_front();
    if (d !== x.dat || e !== x.err) begin n_err++; $display("FAIL read_data: %h/%b expected %h/%b", d, e, x.dat, x.err); end
    @(negedge clk);
  endtask

  task automatic test_write;
    int lat, sc, extra; logic [N_SLAVES-1:0] so; bit got; logic [31:0] d; logic e; exp_t x;
    ack_delay[3] = 5; rdata[3] = 32'h0BAD_F00D;
    drive_req(32'h3003_0000, 1'b1, 32'hA5A5_A5A5, 4'b0011);
    push_exp(32'h0BAD_F00D, 1'b0);
    wait_ack(30, lat, sc, so, got, d, e);
    drop_req();
    n_vec++;
    if (!got || lat != 7 || sc != 6 || so !== 4'b1000) begin
      n_err++; $display("FAIL write_timing: got=%0d lat=%0d stb_cycles=%0d mask=%b expected 7/6/1000", got, lat, sc, so);
    end
    n_vec++;
    if (bus.s_dat_o !== 32'hA5A5_A5A5 || bus.s_sel_o !== 4'b0011 || bus.s_we_o !== 1'b1 || bus.s_adr_o !== 32'h3003_0000) begin
      n_err++; $display("FAIL write_fields: dat=%h sel=%b we=%b adr=%h", bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_adr_o);
    end
    n_vec++;
    x = sb_q.pop_front();
    if (d !== x.dat || e !== x.err) begin n_err++; $display("FAIL write_resp: %h/%b expected %h/%b", d, e, x.dat, x.err); end
    extra = 0;
    repeat (4) begin @(negedge clk); if (bus.wbs_ack_o !== 1'b0) extra++; end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL write_single_ack: %0d extra ack cycles expected 0", extra); end
  endtask

  task automatic test_decode_err;
    int lat, sc; logic [N_SLAVES-1:0] so; bit got; logic [31:0] d; logic e; exp_t x;
    logic [31:0] adrs[3];
    adrs[0] = 32'h3005_0000; adrs[1] = 32'h2000_0000; adrs[2] = 32'h3007_0000;
    for (int k = 0; k < 3; k++) begin
      drive_req(adrs[k], 1'b0, 32'h0, 4'hF);
      bus.err_clr_i = (k == 2);  // clear coinciding with the setting edge
      push_exp(ERR_DATA, 1'b1);
      wait_ack(20, lat, sc, so, got, d, e);
      drop_req();
      n_vec++;
      if (!got || lat != 2 || sc != 0) begin
        n_err++; $display("FAIL decode_timing[%0d]: got=%0d lat=%0d stb_cycles=%0d expected 2/0", k, got, lat, sc);
      end
      n_vec++;
      x = sb_q.pop_front();
      if (d !== x.dat || e !== x.err) begin n_err++; $display("FAIL decode_resp[%0d]: %h/%b expected %h/%b", k, d, e, x.dat, x.err); end
      n_vec++;
      if (bus.err_adr_o !== adrs[k]) begin n_err++; $display("FAIL decode_err_adr[%0d]: %h expected %h", k, bus.err_adr_o, adrs[k]); end
      @(negedge clk);
      if (k == 1 || k == 2) begin
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        bus.err_clr_i = 1'b0;
        n_vec++;
        if (bus.err_o !== 1'b0 || bus.err_adr_o !== adrs[k]) begin
          n_err++; $display("FAIL decode_clear[%0d]: err=%b err_adr=%h expected 0/%h", k, bus.err_o, bus.err_adr_o, adrs[k]);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int lat, sc; logic [N_SLAVES-1:0] so; bit got; logic [31:0] d; logic e;
`ifdef XBAR_TIMEOUT_EN
    exp_t x;
`endif
    ack_delay[2] = NEVER; rdata[2] = 32'h2222_2222;
    drive_req(32'h3002_0010, 1'b0, 32'h0, 4'hF);
`ifdef XBAR_TIMEOUT_EN
    push_exp(ERR_DATA, 1'b1);
    wait_ack(40, lat, sc, so, got, d, e);
    drop_req();
    n_vec++;
    if (!got || lat != 10 || sc != 8 || so !== 4'b0100) begin
      n_err++; $display("FAIL timeout_timing: got=%0d lat=%0d stb_cycles=%0d mask=%b expected 10/8/0100", got, lat, sc, so);
    end
    n_vec++;
    x = sb_q.pop_front();
    if (d !== x.dat || e !== x.err || bus.err_adr_o !== 32'h3002_0010) begin
      n_err++; $display("FAIL timeout_resp: %h/%b adr=%h expected %h/%b/30020010", d, e, bus.err_adr_o, x.dat, x.err);
    end
    @(negedge clk);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
`else
    wait_ack(100, lat, sc, so, got, d, e);
    n_vec++;
    if (got || sc != 100 || so !== 4'b0100) begin
      n_err++; $display("FAIL hang_wait: got=%0d stb_cycles=%0d mask=%b expected 0/100/0100", got, sc, so);
    end
    drop_req();
    @(negedge clk);
    n_vec++;
    if (bus.s_stb_o !== '0 || bus.s_cyc_o !== '0 || bus.wbs_ack_o !== 1'b0) begin
      n_err++; $display("FAIL hang_abort: stb=%b cyc=%b ack=%b expected 0", bus.s_stb_o, bus.s_cyc_o, bus.wbs_ack_o);
    end
`endif
    // A fresh read proves the controller is back in IDLE
    ack_delay[0] = 0; rdata[0] = 32'h0000_C0DE;
    drive_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
    push_exp(32'h0000_C0DE, 1'b0);
    wait_ack(20, lat, sc, so, got, d, e);
    drop_req();
    n_vec++;
    if (!got || lat != 2 || d !== sb_q[0].dat || e !== 1'b0) begin
      n_err++; $display("FAIL post_hang_read: got=%0d lat=%0d dat=%h err=%b expected 2/0000c0de/0", got, lat, d, e);
    end
    void'(sb_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, sc; logic [N_SLAVES-1:0] so; bit got; logic [31:0] d; logic e; exp_t x;
    ack_delay[0] = 0; rdata[0] = 32'hAAAA_0000;
    ack_delay[1] = 0; rdata[1] = 32'hBBBB_1111;
    drive_req(32'h3000_0020, 1'b0, 32'h0, 4'hF);
    push_exp(32'hAAAA_0000, 1'b0);
    wait_ack(20, lat, sc, so, got, d, e);
    drive_req(32'h3001_0040, 1'b0, 32'h0, 4'hF);
    push_exp(32'hBBBB_1111, 1'b0);
    n_vec++;
    x = sb_q.pop_front();
    if (!got || lat != 2 || d !== x.dat || e !== x.err) begin
      n_err++; $display("FAIL b2b_first: got=%0d lat=%0d dat=%h expected 2/%h", got, lat, d, x.dat);
    end
    wait_ack(20, lat, sc, so, got, d, e);
    drop_req();
    n_vec++;
    if (!got || lat != 3 || so !== 4'b0010 || sc != 1) begin
      n_err++; $display("FAIL b2b_second_timing: got=%0d lat=%0d mask=%b stb_cycles=%0d expected 3/0010/1", got, lat, so, sc);
    end
    n_vec++;
    x = sb_q.pop_front();
    if (d !== x.dat || e !== x.err) begin n_err++; $display("FAIL b2b_second_data: %h/%b expected %h/%b", d, e, x.dat, x.err); end
    @(negedge clk);
  endtask

  task automatic test_reset_busy;
    int acks;
    ack_delay[2] = NEVER;
    drive_req(32'h3002_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    n_vec++;
    if (bus.s_stb_o !== 4'b0100) begin n_err++; $display("FAIL rstbusy_strobe: %b expected 0100", bus.s_stb_o); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.wbs_ack_o, bus.s_cyc_o, bus.s_stb_o, bus.err_o, bus.s_we_o} !== '0 ||
        {bus.wbs_dat_o, bus.s_adr_o, bus.s_dat_o, bus.err_adr_o, bus.s_sel_o} !== '0) begin
      n_err++; $display("FAIL rstbusy_outputs: ack=%b stb=%b adr=%h err_adr=%h expected zero",
                        bus.wbs_ack_o, bus.s_stb_o, bus.s_adr_o, bus.err_adr_o);
    end
    drop_req();
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (5) begin @(negedge clk); if (bus.wbs_ack_o !== 1'b0) acks++; end
    n_vec++;
    if (acks != 0) begin n_err++; $display("FAIL rstbusy_no_ack: %0d ack cycles expected 0", acks); end
  endtask

  initial begin
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      ack_delay[i] = 0;
      rdata[i]     = 32'h0;
      scnt[i]      = 0;
    end
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    n_vec++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
